step_seq: RTL and testbench



---
 rtl/step_pkg.sv | 21 ++
 rtl/step_seq_if.sv | 22 ++
 rtl/step_cmd_fifo.sv | 57 +++++
 rtl/step_seq.sv | 135 +++++++++++++
 tb/tb_step_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_pkg.sv
// Shared types for the step command sequencer: FSM state encoding,
// the queued command record and the step count width.
package step_pkg;

    localparam int STEP_COUNT_W = 31;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        ARM,
        RUN
    } state_t;

    typedef struct packed {
        logic [31:0]             reduction;
        logic [STEP_COUNT_W-1:0] count;
        logic                    dir;
    } cmd_t;

endpackage

// File: rtl/step_seq_if.sv
// Motion command valid/ready channel into the sequencer.
// master: drives cmd_valid/cmd_reduction/cmd_count/cmd_dir; slave: drives cmd_ready.
interface step_seq_if;
    import step_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [31:0]             cmd_reduction;
    logic [STEP_COUNT_W-1:0] cmd_count;
    logic                    cmd_dir;

    modport master (
        output cmd_valid, cmd_reduction, cmd_count, cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_reduction, cmd_count, cmd_dir,
        output cmd_ready
    );

endinterface

// File: rtl/step_cmd_fifo.sv
// Single-clock command FIFO with synchronous flush (flush beats push and pop).
// Ports: clk, reset_n, flush, push/wdata, pop/rdata, full, empty, level.
module step_cmd_fifo
    import step_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        push,
    input  cmd_t        wdata,
    input  logic        pop,
    output cmd_t        rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/step_seq.sv
// Step command sequencer: queues segments, feeds the step pulse generator
// one at a time and owns the direction output.
// Ports: clk, reset_n, cmd (slave channel), abort, gen_reduction, gen_count,
// gen_reset, gen_finish, dir, busy, seg_done, level.
// Macro STEP_SEQ_DIR_SETUP_EN: hold dir DIR_SETUP cycles before a reversed start.
module step_seq
    import step_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DIR_SETUP = 16,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    step_seq_if.slave               cmd,
    input  logic                    abort,
    output logic [31:0]             gen_reduction,
    output logic [STEP_COUNT_W-1:0] gen_count,
    output logic                    gen_reset,
    input  logic                    gen_finish,
    output logic                    dir,
    output logic                    busy,
    output logic                    seg_done,
    output logic [LW-1:0]           level
);

    localparam int SW = $clog2(DIR_SETUP + 1);

    state_t        state;
    state_t        state_nx;
    cmd_t          head;
    cmd_t          wdata;
    logic          full;
    logic          empty;
    logic          pop;
    logic          load;
    logic          flip;
    logic          parked;
    logic [SW-1:0] setup_cnt;

    assign wdata = '{reduction: cmd.cmd_reduction,
                     count:     cmd.cmd_count,
                     dir:       cmd.cmd_dir};

    step_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (abort),
        .push    (cmd.cmd_valid),
        .wdata   (wdata),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign cmd.cmd_ready = !full;
    assign gen_reset     = (state == START);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        load     = 1'b0;
        flip     = 1'b0;
        if (abort) begin
            // Restart the generator with count 0 to park it.
            if (state != IDLE) state_nx = START;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        pop = 1'b1;
                        if (head.count != '0) begin
                            load = 1'b1;
                            if (head.dir != dir) begin
                                flip = 1'b1;
`ifdef STEP_SEQ_DIR_SETUP_EN
                                state_nx = SETUP;
`else
                                state_nx = START;
`endif
                            end else begin
                                state_nx = START;
                            end
                        end
                    end
                end
                SETUP: begin
                    if (setup_cnt == SW'(DIR_SETUP - 1)) state_nx = START;
                end
                START:   state_nx = ARM;
                ARM:     state_nx = RUN;
                RUN: begin
                    if (gen_finish) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_reduction <= 32'd1;
            gen_count     <= '0;
            dir           <= 1'b0;
            seg_done      <= 1'b0;
            parked        <= 1'b0;
            setup_cnt     <= '0;
        end else begin
            seg_done <= !abort && (state == RUN) && gen_finish && !parked;
            if ((state == SETUP) && !abort) setup_cnt <= setup_cnt + SW'(1);
            else                             setup_cnt <= '0;
            // parked marks the run after an abort so it ends silently.
            if (abort && (state != IDLE)) begin
                gen_count <= '0;
                parked    <= 1'b1;
            end else if ((state == RUN) && gen_finish) begin
                parked <= 1'b0;
            end
            if (load) begin
                gen_reduction <= (head.reduction == '0) ? 32'd1 : head.reduction;
                gen_count     <= head.count;
            end
            if (flip) dir <= head.dir;
        end
    end

endmodule

// File: tb/tb_step_seq.sv
// Directed self-checking bench for step_seq with a behavioural generator model.
// Generator: finish drops on gen_reset and rises count*reduction cycles later.
module tb_step_seq;
    import step_pkg::*;

`ifdef STEP_SEQ_DIR_SETUP_EN
    localparam int EXP_SETUP = 16;
`else
    localparam int EXP_SETUP = 0;
`endif

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    abort;
    logic [31:0]             gen_reduction;
    logic [STEP_COUNT_W-1:0] gen_count;
    logic                    gen_reset;
    logic                    gen_finish;
    logic                    dir;
    logic                    busy;
    logic                    seg_done;
    logic [2:0]              level;

    int checks   = 0;
    int failures = 0;

    int cyc      = 0;
    int push_cyc = 0;
    int rst_cyc  = 0;
    int rst_cnt  = 0;
    int done_cnt = 0;
    int dir_cyc  = 0;
    int dir_chg  = 0;
    int rst_log [64];
    logic dir_q  = 1'b0;
    int timer;

    int b_rst;
    int b_done;
    int b_dir;

    step_seq_if bif ();

    step_seq #(.DEPTH(4), .DIR_SETUP(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd           (bif),
        .abort         (abort),
        .gen_reduction (gen_reduction),
        .gen_count     (gen_count),
        .gen_reset     (gen_reset),
        .gen_finish    (gen_finish),
        .dir           (dir),
        .busy          (busy),
        .seg_done      (seg_done),
        .level         (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_finish <= 1'b1;
            timer      <= 0;
        end else if (gen_reset) begin
            gen_finish <= 1'b0;
            timer      <= int'(gen_count) * int'(gen_reduction);
        end else if (timer != 0) begin
            timer <= timer - 1;
        end else begin
            gen_finish <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (bif.cmd_valid && bif.cmd_ready) push_cyc = cyc;
        if (gen_reset) begin
            if (rst_cnt < 64) rst_log[rst_cnt] = int'(gen_count);
            rst_cyc = cyc;
            rst_cnt++;
        end
        if (seg_done) done_cnt++;
        if (dir !== dir_q) begin
            dir_cyc = cyc;
            dir_chg++;
        end
        dir_q = dir;
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] r, input logic [30:0] c,
                        input logic d);
        logic ok;
        ok = 1'b0;
        bif.cmd_valid     = 1'b1;
        bif.cmd_reduction = r;
        bif.cmd_count     = c;
        bif.cmd_dir       = d;
        for (int i = 0; i < 300; i++) begin
            if (bif.cmd_ready) begin
                step(1);
                ok = 1'b1;
                break;
            end
            step(1);
        end
        bif.cmd_valid = 1'b0;
        if (!ok) check("push_accept", ok, 1);
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy && level == 0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        check(tag, ok, 1);
        step(2);
    endtask

    task automatic snap();
        b_rst  = rst_cnt;
        b_done = done_cnt;
        b_dir  = dir_chg;
    endtask

    initial begin
        reset_n           = 1'b0;
        abort             = 1'b0;
        bif.cmd_valid     = 1'b0;
        bif.cmd_reduction = '0;
        bif.cmd_count     = '0;
        bif.cmd_dir       = 1'b0;
        step(3);

        check("rst_ready", bif.cmd_ready, 1);
        check("rst_red", gen_reduction, 1);
        check("rst_count", gen_count, 0);
        check("rst_genrst", gen_reset, 0);
        check("rst_dir", dir, 0);
        check("rst_busy", busy, 0);
        check("rst_done", seg_done, 0);
        check("rst_level", level, 0);
        reset_n = 1'b1;
        step(1);

        // single segment
        snap();
        push(32'd3, 31'd2, 1'b0);
        wait_idle("t1_idle");
        check("t1_rst_lat", rst_cyc - push_cyc, 2);
        check("t1_rst_n", rst_cnt - b_rst, 1);
        check("t1_done_n", done_cnt - b_done, 1);
        check("t1_busy", busy, 0);
        check("t1_red", gen_reduction, 3);

        // fill the FIFO behind a long segment
        snap();
        push(32'd3, 31'd10, 1'b0);
        push(32'd1, 31'd2, 1'b0);
        push(32'd1, 31'd3, 1'b0);
        push(32'd1, 31'd4, 1'b0);
        push(32'd1, 31'd5, 1'b0);
        check("t2_level4", level, 4);
        check("t2_stall", bif.cmd_ready, 0);
        push(32'd1, 31'd6, 1'b0);
        check("t2_accept_at_pop", rst_cnt - b_rst, 2);
        wait_idle("t2_idle");
        check("t2_rst_n", rst_cnt - b_rst, 6);
        check("t2_done_n", done_cnt - b_done, 6);
        for (int k = 1; k < 6; k++)
            check($sformatf("t2_order%0d", k), rst_log[b_rst + k], k + 1);

        // direction reversal
        snap();
        push(32'd1, 31'd2, 1'b1);
        wait_idle("t3_idle");
        check("t3_dir", dir, 1);
        check("t3_dir_chg", dir_chg - b_dir, 1);
        check("t3_setup", rst_cyc - dir_cyc, EXP_SETUP);
        check("t3_lat", rst_cyc - push_cyc, 2 + EXP_SETUP);

        // zero-count entry between two valid ones
        snap();
        push(32'd1, 31'd1, 1'b1);
        push(32'd5, 31'd0, 1'b0);
        push(32'd2, 31'd1, 1'b1);
        wait_idle("t4_idle");
        check("t4_rst_n", rst_cnt - b_rst, 2);
        check("t4_done_n", done_cnt - b_done, 2);
        check("t4_dir", dir, 1);
        check("t4_dir_chg", dir_chg - b_dir, 0);
        check("t4_red", gen_reduction, 2);

        // zero reduction is loaded as 1
        push(32'd0, 31'd3, 1'b1);
        wait_idle("t4z_idle");
        check("t4z_red", gen_reduction, 1);
        check("t4z_cnt", gen_count, 3);

        // abort during RUN with two queued
        snap();
        push(32'd2, 31'd20, 1'b1);
        push(32'd1, 31'd1, 1'b1);
        push(32'd1, 31'd2, 1'b1);
        step(6);
        check("t5_level2", level, 2);
        check("t5_busy", busy, 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t5_level0", level, 0);
        check("t5_cnt0", gen_count, 0);
        check("t5_start", gen_reset, 1);
        wait_idle("t5_idle");
        check("t5_rst_n", rst_cnt - b_rst, 2);
        check("t5_park_cnt", rst_log[b_rst + 1], 0);
        check("t5_done_n", done_cnt - b_done, 0);

        // asynchronous reset mid-RUN
        push(32'd2, 31'd20, 1'b1);
        step(8);
        check("t6_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_ready", bif.cmd_ready, 1);
        check("t6_red", gen_reduction, 1);
        check("t6_count", gen_count, 0);
        check("t6_genrst", gen_reset, 0);
        check("t6_dir", dir, 0);
        check("t6_busy0", busy, 0);
        check("t6_done", seg_done, 0);
        check("t6_level", level, 0);
        step(2);
        reset_n = 1'b1;
        step(1);
        snap();
        push(32'd3, 31'd2, 1'b0);
        wait_idle("t6_idle");
        check("t6_lat", rst_cyc - push_cyc, 2);
        check("t6_done_n", done_cnt - b_done, 1);
        check("t6_rst_n", rst_cnt - b_rst, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
